id_lookup_ctrl: RTL and testbench
=================================

// Module: id_lookup_ctrl
// PURPOSE
//  Sequences the synchronous 40-bit ID ROM to authenticate a 10-digit BCD ID.
//  On start it latches the candidate ID, scans ROM entries 0..DEPTH-1, and
//  compares each word against the candidate. It reports hit/miss and the
//  matching index. It sits between the keypad/ID capture logic and the ROM,
//  and is the only master of the ROM address bus.
// PARAMETERS
//  DEPTH  5   number of valid ROM entries scanned (indices 0..DEPTH-1)
//  AW     4   ROM address width; DEPTH <= 2**AW
//  DW     40  ID / ROM word width (10 BCD digits, MS digit in [DW-1:DW-4])
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   request a lookup; sampled only in IDLE
//  id_in      in   DW  candidate ID; latched on the accepting edge
//  rom_addr   out  AW  address to ROM (registered)
//  rom_data   in   DW  ROM read data, valid 1 cycle after rom_addr
//  busy       out  1   high from the accepting edge until done
//  done       out  1   1-cycle pulse: result valid
//  match      out  1   1 = ID found; held until next accepted start
//  match_idx  out  AW  index of hit (0 on miss); held like match
//  id_err     out  1   malformed-ID flag (see CONFIGURATION); held like match
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; rom_addr, busy, done, match,
//    match_idx, id_err and the ID latch all 0. Reset mid-scan aborts with no done.
//  - FSM: IDLE -> FETCH -> CMP -> {FETCH | DONE} -> IDLE.
//  - IDLE: start=1 at an edge -> latch id_in, idx=0, rom_addr=0, busy=1,
//    clear match/match_idx/id_err, go to FETCH.
//  - FETCH (1 cycle): rom_addr=idx held; ROM registers the word; go to CMP.
//  - CMP: rom_data valid. If rom_data==latched ID -> match=1, match_idx=idx,
//    go to DONE. Else if idx==DEPTH-1 -> match=0, match_idx=0, go to DONE.
//    Else idx++ (and rom_addr), go to FETCH.
//  - DONE (1 cycle): done=1, busy=0 at next edge; return to IDLE.
//  - Latency: 2 cycles per entry. Hit at index k: done high in cycle
//    2k+3 after the accepting edge (edge = cycle 0). Miss: cycle 2*DEPTH+1.
//  - start while busy or in DONE: ignored, id_in not re-latched.
//  - start held high: a new lookup is accepted on the first IDLE edge.
//  - First match wins. Duplicate ROM entries report the lowest index.
//  - Exact DW-bit equality. An all-zero ID is compared like any other.
//  - rom_addr never exceeds DEPTH-1. It holds its last value in IDLE/DONE.
// CONFIGURATION
//  ID_BCD_CHECK_EN defined:
//   - On accept, if any 4-bit digit of id_in is >9, skip the scan and go
//     IDLE -> DONE.
//   - done pulses in cycle 1, with id_err=1, match=0 and match_idx=0.
//   - rom_addr is not changed.
//  ID_BCD_CHECK_EN undefined:
//   - No digit check. id_err is tied 0.
//   - Malformed IDs are scanned and simply miss.
// TESTING
//  1 rst pulse mid-run -> all outputs 0 immediately; busy=0; no done pulse.
//  2 start, id_in=40'h1022440206 -> rom_addr=0; done in cycle 3;
//    match=1, match_idx=0.
//  3 start, id_in=40'h1020833802 -> addresses 0..4 visited in order;
//    done in cycle 11; match=1, match_idx=4.
//  4 start, id_in=40'h1234567890 -> done in cycle 11; match=0, match_idx=0;
//    rom_addr stays 4.
//  5 start, id_in=40'h1015480227, then start with id_in=40'h1022440206
//    during busy -> second request ignored; result match=1, match_idx=1.
//  6 ID_BCD_CHECK_EN on: id_in=40'h10224402A6 -> done in cycle 1,
//    id_err=1, match=0. Macro off: same stimulus -> done in cycle 11,
//    id_err=0, match=0.

Source files
------------

// File: rtl/id_lookup_if.sv
// rtl/id_lookup_if.sv - request/result and ROM bus bundle for id_lookup_ctrl
// Ports (signals):
//   start     requester -> ctrl   lookup request
//   id_in     requester -> ctrl   candidate ID (DW bits)
//   rom_addr  ctrl -> ROM         registered ROM address (AW bits)
//   rom_data  ROM -> ctrl         ROM word, valid one cycle after rom_addr
//   busy, done, match, match_idx, id_err   ctrl -> requester results
// Modports: slave = controller side, master = requester/ROM side.
interface id_lookup_if #(
    parameter int AW = 4,
    parameter int DW = 40
);
    logic          start;
    logic [DW-1:0] id_in;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          busy;
    logic          done;
    logic          match;
    logic [AW-1:0] match_idx;
    logic          id_err;

    modport master (
        output start, id_in, rom_data,
        input  rom_addr, busy, done, match, match_idx, id_err
    );

    modport slave (
        input  start, id_in, rom_data,
        output rom_addr, busy, done, match, match_idx, id_err
    );
endinterface

// File: rtl/id_lookup_ctrl.sv
// rtl/id_lookup_ctrl.sv - sequential ID ROM scanner reporting hit/miss and index
// Scans ROM entries 0..DEPTH-1 against a latched 10-digit BCD candidate ID.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   id_lookup_if.slave: start/id_in in, rom_addr out, rom_data in,
//         busy/done/match/match_idx/id_err out (all outputs registered)
// Optional feature macro: ID_BCD_CHECK_EN - reject IDs containing a digit >9
// without scanning; when undefined id_err is tied low.
module id_lookup_ctrl #(
    parameter int DEPTH = 5,
    parameter int AW    = 4,
    parameter int DW    = 40
) (
    input  logic           clk,
    input  logic           rst,
    id_lookup_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, FETCH, CMP, DONE} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state;
    logic [DW-1:0] id_q;
    logic [AW-1:0] addr_q;      // doubles as the scan index
    logic          busy_q;
    logic          done_q;
    logic          match_q;
    logic [AW-1:0] match_idx_q;

    assign bus.rom_addr  = addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.match     = match_q;
    assign bus.match_idx = match_idx_q;

`ifdef ID_BCD_CHECK_EN
    logic err_q;
    assign bus.id_err = err_q;

    function automatic logic bad_bcd(input logic [DW-1:0] id);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DW / 4; i++) begin
            if (id[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction
`else
    assign bus.id_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
            match_idx_q <= '0;
`ifdef ID_BCD_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        id_q        <= bus.id_in;
                        busy_q      <= 1'b1;
                        match_q     <= 1'b0;
                        match_idx_q <= '0;
`ifdef ID_BCD_CHECK_EN
                        // Malformed IDs skip the scan and leave rom_addr alone.
                        if (bad_bcd(bus.id_in)) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            err_q  <= 1'b0;
                            addr_q <= '0;
                            state  <= FETCH;
                        end
`else
                        addr_q <= '0;
                        state  <= FETCH;
`endif
                    end
                end
                FETCH: begin
                    // ROM captures addr_q on this edge; data is valid in CMP.
                    state <= CMP;
                end
                CMP: begin
                    if (bus.rom_data == id_q) begin
                        match_q     <= 1'b1;
                        match_idx_q <= addr_q;
                        state       <= DONE;
                    end else if (addr_q == LAST_IDX) begin
                        match_q     <= 1'b0;
                        match_idx_q <= '0;
                        state       <= DONE;
                    end else begin
                        addr_q <= addr_q + AW'(1);
                        state  <= FETCH;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_id_lookup_ctrl.sv
// tb/tb_id_lookup_ctrl.sv - directed self-checking bench for id_lookup_ctrl
module tb_id_lookup_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [39:0] rom [0:15];
    logic [3:0]  addr_log [0:63];
    int          done_cyc;
    int          max_addr;

    id_lookup_if #(.AW(4), .DW(40)) bus ();

    id_lookup_ctrl #(.DEPTH(5), .AW(4), .DW(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: one-cycle read latency.
    always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic do_lookup(input logic [39:0] id);
        @(negedge clk);
        bus.start = 1'b1;
        bus.id_in = id;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        addr_log[0] = bus.rom_addr;
        done_cyc = -1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(posedge clk);
            #1;
            addr_log[c] = bus.rom_addr;
            if (int'(bus.rom_addr) > max_addr) max_addr = int'(bus.rom_addr);
            if (bus.done) done_cyc = c;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL reset_match got %b want 0", bus.match); end
        checks++; if (bus.match_idx !== 4'd0) begin errors++; $display("FAIL reset_match_idx got %0d want 0", bus.match_idx); end
        checks++; if (bus.rom_addr !== 4'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", bus.rom_addr); end
        checks++; if (bus.id_err !== 1'b0) begin errors++; $display("FAIL reset_id_err got %b want 0", bus.id_err); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_hit_first;
        @(negedge clk);
        bus.start = 1'b1;
        bus.id_in = 40'h1022440206;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hit0_busy_after_accept got %b want 1", bus.busy); end
        checks++; if (bus.rom_addr !== 4'd0) begin errors++; $display("FAIL hit0_rom_addr got %0d want 0", bus.rom_addr); end
        done_cyc = -1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cyc = c;
        end
        checks++; if (done_cyc != 3) begin errors++; $display("FAIL hit0_done_cycle got %0d want 3", done_cyc); end
        checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL hit0_match got %b want 1", bus.match); end
        checks++; if (bus.match_idx !== 4'd0) begin errors++; $display("FAIL hit0_match_idx got %0d want 0", bus.match_idx); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hit0_busy_at_done got %b want 0", bus.busy); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL hit0_done_pulse_width got %b want 0", bus.done); end
        checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL hit0_match_held got %b want 1", bus.match); end
    endtask

    task automatic test_hit_last;
        do_lookup(40'h1020833802);
        checks++; if (done_cyc != 11) begin errors++; $display("FAIL hit4_done_cycle got %0d want 11", done_cyc); end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (addr_log[2*j+1] !== 4'(j)) begin
                errors++; $display("FAIL hit4_addr_order cycle %0d got %0d want %0d", 2*j+1, addr_log[2*j+1], j);
            end
        end
        checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL hit4_match got %b want 1", bus.match); end
        checks++; if (bus.match_idx !== 4'd4) begin errors++; $display("FAIL hit4_match_idx got %0d want 4", bus.match_idx); end
    endtask

    task automatic test_miss;
        do_lookup(40'h1234567890);
        checks++; if (done_cyc != 11) begin errors++; $display("FAIL miss_done_cycle got %0d want 11", done_cyc); end
        checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL miss_match got %b want 0", bus.match); end
        checks++; if (bus.match_idx !== 4'd0) begin errors++; $display("FAIL miss_match_idx got %0d want 0", bus.match_idx); end
        checks++; if (bus.rom_addr !== 4'd4) begin errors++; $display("FAIL miss_rom_addr got %0d want 4", bus.rom_addr); end
    endtask

    task automatic test_bcd_check;
        do_lookup(40'h10224402A6);
`ifdef ID_BCD_CHECK_EN
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL bcd_done_cycle got %0d want 1", done_cyc); end
        checks++; if (bus.id_err !== 1'b1) begin errors++; $display("FAIL bcd_id_err got %b want 1", bus.id_err); end
`else
        checks++; if (done_cyc != 11) begin errors++; $display("FAIL bcd_done_cycle got %0d want 11", done_cyc); end
        checks++; if (bus.id_err !== 1'b0) begin errors++; $display("FAIL bcd_id_err got %b want 0", bus.id_err); end
`endif
        checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL bcd_match got %b want 0", bus.match); end
        checks++; if (bus.match_idx !== 4'd0) begin errors++; $display("FAIL bcd_match_idx got %0d want 0", bus.match_idx); end
        checks++; if (bus.rom_addr !== 4'd4) begin errors++; $display("FAIL bcd_rom_addr got %0d want 4", bus.rom_addr); end
    endtask

    task automatic test_start_while_busy;
        @(negedge clk);
        bus.start = 1'b1;
        bus.id_in = 40'h1015480227;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin bus.start = 1'b1; bus.id_in = 40'h1022440206; end
            if (c == 3) bus.start = 1'b0;
            if (bus.done) done_cyc = c;
        end
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL busy_ign_done_cycle got %0d want 5", done_cyc); end
        checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL busy_ign_match got %b want 1", bus.match); end
        checks++; if (bus.match_idx !== 4'd1) begin errors++; $display("FAIL busy_ign_match_idx got %0d want 1", bus.match_idx); end
        checks++; if (bus.id_err !== 1'b0) begin errors++; $display("FAIL busy_ign_id_err got %b want 0", bus.id_err); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_ign_no_restart got %b want 0", bus.busy); end
    endtask

    task automatic test_start_held;
        int n_done;
        int first_done;
        int second_done;
        n_done = 0; first_done = -1; second_done = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.id_in = 40'h1022440206;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) bus.start = 1'b0;
            if (bus.done) begin
                n_done++;
                if (n_done == 1) first_done = c;
                if (n_done == 2) second_done = c;
            end
        end
        checks++; if (first_done != 3) begin errors++; $display("FAIL held_first_done got %0d want 3", first_done); end
        checks++; if (second_done != 7) begin errors++; $display("FAIL held_second_done got %0d want 7", second_done); end
        checks++; if (n_done != 2) begin errors++; $display("FAIL held_done_count got %0d want 2", n_done); end
    endtask

    task automatic test_dup_and_zero;
        rom[3] = 40'h1015480227;
        do_lookup(40'h1015480227);
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL dup_done_cycle got %0d want 5", done_cyc); end
        checks++; if (bus.match_idx !== 4'd1) begin errors++; $display("FAIL dup_match_idx got %0d want 1", bus.match_idx); end
        rom[3] = 40'h1047795501;
        rom[2] = 40'h0;
        do_lookup(40'h0);
        checks++; if (done_cyc != 7) begin errors++; $display("FAIL zero_done_cycle got %0d want 7", done_cyc); end
        checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL zero_match got %b want 1", bus.match); end
        checks++; if (bus.match_idx !== 4'd2) begin errors++; $display("FAIL zero_match_idx got %0d want 2", bus.match_idx); end
        rom[2] = 40'h1031122334;
    endtask

    task automatic test_reset_mid_run;
        int pulses;
        do_lookup(40'h1020833802);
        checks++; if (bus.match_idx !== 4'd4) begin errors++; $display("FAIL rst_pre_match_idx got %0d want 4", bus.match_idx); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL rst_idle_match got %b want 0", bus.match); end
        checks++; if (bus.match_idx !== 4'd0) begin errors++; $display("FAIL rst_idle_match_idx got %0d want 0", bus.match_idx); end
        checks++; if (bus.rom_addr !== 4'd0) begin errors++; $display("FAIL rst_idle_rom_addr got %0d want 0", bus.rom_addr); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.id_in = 40'h1020833802;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
        checks++; if (bus.rom_addr !== 4'd0) begin errors++; $display("FAIL rst_mid_rom_addr got %0d want 0", bus.rom_addr); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", bus.done); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d pulses want 0", pulses); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_after got %b want 0", bus.busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        max_addr = 0;
        bus.start = 1'b0;
        bus.id_in = '0;
        for (int i = 0; i < 16; i++) rom[i] = 40'h9999999999;
        rom[0] = 40'h1022440206;
        rom[1] = 40'h1015480227;
        rom[2] = 40'h1031122334;
        rom[3] = 40'h1047795501;
        rom[4] = 40'h1020833802;

        test_reset;
        test_hit_first;
        test_hit_last;
        test_miss;
        test_bcd_check;
        test_start_while_busy;
        test_start_held;
        test_dup_and_zero;
        test_reset_mid_run;

        checks++; if (max_addr > 4) begin errors++; $display("FAIL rom_addr_bound got %0d want <=4", max_addr); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
